// File: rtl/branch_target_table.sv
// -----------------------------------------------------------------------------
// branch_target_table
//
// Programmable branch-target table. The fetch stage indexes it with the
// branch-target field of an instruction. The table returns the next-PC target.
//
// Each entry holds {rel, data}:
//   - rel = 0 : data is an absolute target.
//   - rel = 1 : data is a signed offset that is added to the PC sampled
//               with the lookup. The sum is truncated to D bits.
//
// After reset the table clears itself, one entry per cycle. It accepts
// reads and writes only once that sweep has finished.
//
// State table
//   state | meaning
//   INIT  | clearing entry init_ctr each cycle; ready=0, requests ignored
//   RUN   | table live; accepts writes and lookups until the next reset
//
// Ports
//   clk           clock, all state updates on the rising edge
//   reset         synchronous, active-high
//   wr_en         write request
//   wr_addr[A]    entry to write
//   wr_data[D]    absolute target, or two's-complement offset
//   wr_rel        1 = entry is PC-relative (honoured only when REL_EN != 0)
//   wr_ack        registered; high one cycle after an accepted write
//   rd_en         lookup request
//   rd_addr[A]    entry to look up
//   pc[D]         current PC, sampled with rd_en
//   target[D]     resolved target, registered; holds when no lookup
//   target_valid  registered; high one cycle after an accepted lookup
//   ready         1 = init sweep done
// -----------------------------------------------------------------------------
module branch_target_table #(
    parameter int D      = 10,
    parameter int A      = 4,
    parameter int REL_EN = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_data,
    input  logic         wr_rel,
    output logic         wr_ack,
    input  logic         rd_en,
    input  logic [A-1:0] rd_addr,
    input  logic [D-1:0] pc,
    output logic [D-1:0] target,
    output logic         target_valid,
    output logic         ready
);

    localparam int DEPTH  = 2 ** A;
    localparam bit REL_ON = (REL_EN != 0);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [A-1:0] init_ctr;

    // Storage is deliberately left without a reset. The init sweep is what
    // clears it.
    logic [D:0]   mem [DEPTH];

    logic         init_we;
    logic         wr_accept;
    logic         rd_accept;
    logic [D:0]   wr_entry;
    logic [D:0]   rd_entry;
    logic [D-1:0] resolved;

    // ------------------------------------------------------------------
    // FSM state register and sweep counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            init_ctr <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) begin
                init_ctr <= init_ctr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and qualified strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        init_we    = 1'b0;
        wr_accept  = 1'b0;
        rd_accept  = 1'b0;
        ready      = 1'b0;
        unique case (state)
            ST_INIT: begin
                init_we = 1'b1;
                if (init_ctr == {A{1'b1}}) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                ready     = 1'b1;
                wr_accept = wr_en;
                rd_accept = rd_en;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    // The relative flag is forced low when relative mode is not built in.
    // Stored entries are then always absolute.
    assign wr_entry = {wr_rel & REL_ON, wr_data};

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_we) begin
                mem[init_ctr] <= '0;
            end else if (wr_accept) begin
                mem[wr_addr] <= wr_entry;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    // Write-first. A write to the same entry in the same cycle is forwarded
    // to the read, so the read sees the new {rel, data}.
    always_comb begin
        rd_entry = mem[rd_addr];
        if (wr_accept && (wr_addr == rd_addr)) begin
            rd_entry = wr_entry;
        end
    end

    // The offset is two's complement. A plain D-bit add gives the wrap
    // modulo 2**D in both directions.
    always_comb begin
        resolved = rd_entry[D-1:0];
        if (REL_ON && rd_entry[D]) begin
            resolved = pc + rd_entry[D-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            target       <= '0;
            target_valid <= 1'b0;
            wr_ack       <= 1'b0;
        end else begin
            target_valid <= rd_accept;
            wr_ack       <= wr_accept;
            if (rd_accept) begin
                target <= resolved;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_table.sv
module tb_branch_target_table;

    localparam int D     = 10;
    localparam int A     = 4;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_data;
    logic         wr_rel;
    logic         rd_en;
    logic [A-1:0] rd_addr;
    logic [D-1:0] pc;

    logic         wr_ack_r, wr_ack_a;
    logic [D-1:0] target_r, target_a;
    logic         tv_r, tv_a;
    logic         ready_r, ready_a;

    always #5 clk = ~clk;

    // Relative mode built in
    branch_target_table #(.D(D), .A(A), .REL_EN(1)) dut_rel (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rel(wr_rel),
        .wr_ack(wr_ack_r),
        .rd_en(rd_en), .rd_addr(rd_addr), .pc(pc),
        .target(target_r), .target_valid(tv_r), .ready(ready_r)
    );

    // Absolute-only build: wr_rel is ignored
    branch_target_table #(.D(D), .A(A), .REL_EN(0)) dut_abs (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rel(wr_rel),
        .wr_ack(wr_ack_a),
        .rd_en(rd_en), .rd_addr(rd_addr), .pc(pc),
        .target(target_a), .target_valid(tv_a), .ready(ready_a)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: contents as written, plus the expected outputs
    logic [D-1:0] m_data [DEPTH];
    logic         m_rel  [DEPTH];
    int           cyc_since_reset;
    logic [D-1:0] e_tgt_r, e_tgt_a;
    logic         e_tv, e_wack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst_i,
                        input logic we_i, input logic [A-1:0] wa_i,
                        input logic [D-1:0] wd_i, input logic wr_i,
                        input logic re_i, input logic [A-1:0] ra_i,
                        input logic [D-1:0] pc_i);
        logic [D-1:0] d_sel;
        logic         r_sel;
        reset   = rst_i;
        wr_en   = we_i;
        wr_addr = wa_i;
        wr_data = wd_i;
        wr_rel  = wr_i;
        rd_en   = re_i;
        rd_addr = ra_i;
        pc      = pc_i;
        @(posedge clk);
        if (rst_i) begin
            // The init sweep that follows leaves every entry zero
            e_tgt_r = '0;
            e_tgt_a = '0;
            e_tv    = 1'b0;
            e_wack  = 1'b0;
            cyc_since_reset = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_data[i] = '0;
                m_rel[i]  = 1'b0;
            end
        end else begin
            if (cyc_since_reset >= DEPTH) begin
                if (we_i && (wa_i == ra_i)) begin
                    d_sel = wd_i;
                    r_sel = wr_i;
                end else begin
                    d_sel = m_data[ra_i];
                    r_sel = m_rel[ra_i];
                end
                e_tv = re_i;
                if (re_i) begin
                    e_tgt_r = r_sel ? D'(pc_i + d_sel) : d_sel;
                    e_tgt_a = d_sel;
                end
                e_wack = we_i;
                if (we_i) begin
                    m_data[wa_i] = wd_i;
                    m_rel[wa_i]  = wr_i;
                end
            end else begin
                e_tv   = 1'b0;
                e_wack = 1'b0;
            end
            if (cyc_since_reset < DEPTH) cyc_since_reset++;
        end
        #1;
        check("ready_rel",  32'(ready_r),  32'(cyc_since_reset >= DEPTH));
        check("ready_abs",  32'(ready_a),  32'(cyc_since_reset >= DEPTH));
        check("wr_ack_rel", 32'(wr_ack_r), 32'(e_wack));
        check("wr_ack_abs", 32'(wr_ack_a), 32'(e_wack));
        check("tvalid_rel", 32'(tv_r),     32'(e_tv));
        check("tvalid_abs", 32'(tv_a),     32'(e_tv));
        check("target_rel", 32'(target_r), 32'(e_tgt_r));
        check("target_abs", 32'(target_a), 32'(e_tgt_a));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [A-1:0] a, input logic [D-1:0] d, input logic r);
        step(1'b0, 1'b1, a, d, r, 1'b0, '0, '0);
    endtask

    task automatic rd(input logic [A-1:0] a, input logic [D-1:0] p);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, a, p);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_rel = 1'b0;
        rd_en = 1'b0; rd_addr = '0; pc = '0;
        cyc_since_reset = 0;
        e_tgt_r = '0; e_tgt_a = '0; e_tv = 1'b0; e_wack = 1'b0;

        // Test 1 and test 6b: a one-cycle reset, then the sweep.
        // Reads and writes issued during the sweep are ignored.
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        for (int k = 1; k <= DEPTH; k++) begin
            if (k == 3)      step(1'b0, 1'b1, 4'd7, 10'd55, 1'b0, 1'b0, '0, '0);
            else if (k == 5) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 4'd7, 10'd1);
            else             idle();
        end
        rd(4'd7, 10'd0);                   // the write issued during the sweep left no trace

        // Test 2: absolute write, then read; target then holds with valid low.
        wr(4'd1, 10'd11, 1'b0);
        rd(4'd1, 10'd500);
        idle();

        // Test 3: relative wrap below 0 and above 1023
        wr(4'd9, 10'h3FB, 1'b1);
        rd(4'd9, 10'd4);
        wr(4'd9, 10'd20, 1'b1);
        rd(4'd9, 10'd1020);

        // Test 4: same-address write-first, and different-address independence
        wr(4'd5, 10'd300, 1'b0);
        step(1'b0, 1'b1, 4'd3, 10'd87, 1'b0, 1'b1, 4'd3, 10'd0);
        step(1'b0, 1'b1, 4'd2, 10'd44, 1'b0, 1'b1, 4'd5, 10'd0);
        rd(4'd2, 10'd0);
        step(1'b0, 1'b1, 4'd6, 10'd3, 1'b1, 1'b1, 4'd6, 10'd1022);

        // Test 6a: relative entry on both builds
        wr(4'd4, 10'd5, 1'b1);
        rd(4'd4, 10'd100);

        // Random traffic: back-to-back mixed reads/writes, with frequent
        // same-address collisions
        for (int n = 0; n < 300; n++) begin
            logic [A-1:0] wa, ra;
            wa = A'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 3) == 0) ? wa : A'($urandom_range(0, DEPTH - 1));
            step(1'b0, 1'($urandom_range(0, 1)), wa, D'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), ra, D'($urandom));
        end

        // Test 5: fill every entry, reset while a read is in flight, then
        // confirm the sweep cleared the table
        for (int i = 0; i < DEPTH; i++) begin
            wr(A'(i), D'($urandom_range(1, 1023)), 1'($urandom_range(0, 1)));
        end
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 4'd8, 10'd9);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 4'd8, 10'd9);
        for (int k = 1; k <= 7; k++) rd(A'(k), 10'd1);
        // Reset again partway through the sweep; the sweep restarts from entry 0
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        for (int k = 1; k <= DEPTH; k++) idle();
        for (int i = 0; i < DEPTH; i++) rd(A'(i), D'($urandom));
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
